// File: rtl/pe_pkg.sv
// Types shared between the 4-bit priority encoder and its downstream event FIFO.
package pe_pkg;

    localparam int unsigned PE_CODE_W = 2;

    typedef logic [PE_CODE_W-1:0] pe_code_t;

endpackage

// File: rtl/pe_fifo_core.sv
// Generic first-word fall-through FIFO with an explicit occupancy counter.
module pe_fifo_core #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CountW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CountW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign count = count_q;
    assign full  = (count_q == CountW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/pe_event_fifo.sv
// Converts the encoder's level output into discrete change events and buffers them,
// tracking dropped events with a sticky flag and a saturating counter.
module pe_event_fifo
    import pe_pkg::*;
#(
    parameter int unsigned CODE_W = PE_CODE_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CODE_W-1:0]      in_code,
    input  logic                   in_valid,
    output logic [CODE_W-1:0]      out_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt,
    input  logic                   clr_ovf
);

    logic              prev_valid_q;
    logic [CODE_W-1:0] prev_code_q;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              evt, push, pop, drop;

    assign evt  = in_valid && (!prev_valid_q || (in_code != prev_code_q));
    assign pop  = out_valid && out_ready;
    assign push = evt && (!full || pop);
    assign drop = evt && full && !pop;

    // A drop in the same cycle as a clear leaves the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != '1) begin
                drop_cnt_d = drop_cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_valid_q <= 1'b0;
            prev_code_q  <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            prev_valid_q <= in_valid;
            prev_code_q  <= in_code;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    pe_fifo_core #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_code),
        .pop   (pop),
        .rdata (out_code),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pe_event_fifo.sv
// Scoreboard bench for pe_event_fifo: queue-based reference model plus a pop monitor.
module tb_pe_event_fifo;

    localparam int unsigned CODE_W  = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int          DropMax = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CODE_W-1:0]      in_code;
    logic                   in_valid;
    logic [CODE_W-1:0]      out_code;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   overflow;
    logic [CNT_W-1:0]       drop_cnt;
    logic                   clr_ovf;

    pe_event_fifo #(
        .CODE_W (CODE_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: stored events, last sampled input, drop bookkeeping.
    int m_q[$];
    int exp_q[$];
    bit m_pv;
    int m_pc;
    bit m_ovf;
    int m_drops;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_pv    = 1'b0;
        m_pc    = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic check_state();
        check("count", int'(count), m_q.size());
        check("empty", int'(empty), (m_q.size() == 0) ? 1 : 0);
        check("full", int'(full), (m_q.size() == DEPTH) ? 1 : 0);
        check("out_valid", int'(out_valid), (m_q.size() != 0) ? 1 : 0);
        check("out_code", int'(out_code), (m_q.size() != 0) ? m_q[0] : 0);
        check("overflow", int'(overflow), int'(m_ovf));
        check("drop_cnt", int'(drop_cnt), m_drops);
    endtask

    // One clock of stimulus; the model advances on the same edge as the DUT.
    task automatic step(input bit v, input int c, input bit r, input bit clr);
        bit m_pop, ev, m_full, m_push, m_drop;
        in_valid  = v;
        in_code   = CODE_W'(c);
        out_ready = r;
        clr_ovf   = clr;
        m_pop  = r && (m_q.size() > 0);
        ev     = v && (!m_pv || (c != m_pc));
        m_full = (m_q.size() == DEPTH);
        m_push = ev && (!m_full || m_pop);
        m_drop = ev && m_full && !m_pop;
        @(posedge clk);
        if (m_pop) begin
            void'(m_q.pop_front());
        end
        if (m_push) begin
            m_q.push_back(c);
            exp_q.push_back(c);
        end
        if (clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
        if (m_drop) begin
            m_ovf   = 1'b1;
            m_drops = (m_drops < DropMax) ? m_drops + 1 : DropMax;
        end
        m_pv = v;
        m_pc = c;
        #1;
        check_state();
    endtask

    // Monitor: every accepted pop must deliver the oldest expected event.
    always @(negedge clk) begin
        int e;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_pop: got code %0d, expected no entry", out_code);
            end else begin
                e = exp_q.pop_front();
                check("sb_code", int'(out_code), e);
            end
        end
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        model_reset();
        #1;
        check_state();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Dedup: a held code produces a single entry.
        repeat (10) step(1, 1, 0, 0);
        check("dedup_count", int'(count), 1);
        check("dedup_code", int'(out_code), 1);
        step(0, 1, 0, 0);
        repeat (2) step(0, 0, 1, 0);

        // Ordering and full.
        for (int i = 0; i < 4; i++) step(1, i, 0, 0);
        check("fill_full", int'(full), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        check("drain_empty", int'(empty), 1);

        // Drop when full, then accept with a concurrent pop.
        for (int i = 0; i < 4; i++) step(1, i, 0, 0);
        step(1, 0, 0, 0);
        check("drop_ovf", int'(overflow), 1);
        check("drop_cnt1", int'(drop_cnt), 1);
        check("drop_count", int'(count), 4);
        step(1, 2, 1, 0);
        check("swap_count", int'(count), 4);
        check("swap_cnt", int'(drop_cnt), 1);
        repeat (4) step(0, 0, 1, 0);

        // Re-arm on a valid rising edge with the same code.
        step(1, 2, 0, 0);
        step(0, 2, 0, 0);
        step(1, 2, 0, 0);
        check("rearm_count", int'(count), 2);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);

        // Saturation, clear alone, clear together with a drop.
        for (int i = 0; i < 4; i++) step(1, i, 0, 0);
        for (int i = 0; i < 260; i++) step(1, i % 4, 0, 0);
        check("sat_cnt", int'(drop_cnt), DropMax);
        check("sat_ovf", int'(overflow), 1);
        step(0, 0, 0, 1);
        check("clr_ovf", int'(overflow), 0);
        check("clr_cnt", int'(drop_cnt), 0);
        step(1, 1, 0, 0);
        step(1, 2, 0, 1);
        check("clr_drop_ovf", int'(overflow), 1);
        check("clr_drop_cnt", int'(drop_cnt), 1);

        // Asynchronous reset between edges with entries and overflow pending.
        repeat (4) step(0, 0, 1, 0);
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_cnt", int'(drop_cnt), 0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) step(0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bit v, r, clr;
            int c;
            v   = ($urandom_range(0, 9) < 8);
            c   = ($urandom_range(0, 1) == 0) ? m_pc : int'($urandom_range(0, 3));
            r   = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 40) == 0);
            step(v, c, r, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_event_fifo.md
Name: pe_event_fifo

Overview:
- Downstream consumer of the 4-bit priority encoder; its inputs connect to the encoder's registered Y/valid outputs.
- Turns the encoder's level-style output into discrete events: a new entry is generated only when valid rises or the encoded index changes.
- Events are buffered in a small FIFO and presented on a valid/ready output for the next stage (arbiter or logger).
- Overflow status and a saturating drop counter make lost events observable.

Parameters:
- CODE_W, 2, width of the encoded index; matches the encoder's Y width.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- in_code  input  CODE_W  encoded index from the priority encoder (Y).
- in_valid  input  1  encoder valid flag.
- out_code  output  CODE_W  head-of-FIFO code.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts the head entry this cycle.
- count  output  $clog2(DEPTH)+1  current number of stored entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky flag; set when an event is dropped.
- drop_cnt  output  CNT_W  number of dropped events, saturating.
- clr_ovf  input  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (rst=0), applied immediately with no clock edge needed:
  - pointers = 0, count = 0, empty = 1, full = 0, out_valid = 0, out_code = 0.
  - overflow = 0, drop_cnt = 0, prev_valid = 0, prev_code = 0.
  - FIFO storage is not reset.
- Reset mid-operation discards all stored entries.
- Event detect:
  - event = in_valid && (!prev_valid || in_code != prev_code).
  - prev_valid and prev_code register in_valid and in_code every cycle, whether or not the event is accepted.
- Pop: pop = out_valid && out_ready.
- Push: push = event && (!full || pop).
  - When full, a simultaneous pop and push is accepted; count is unchanged and the pointers advance.
- Drop: drop = event && full && !pop.
  - On drop: overflow <= 1; drop_cnt increments and saturates at 2^CNT_W-1.
  - Storage and count are unchanged.
- clr_ovf = 1 at a posedge: overflow <= 0, drop_cnt <= 0.
  - If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_cnt = 1.
- Output is first-word fall-through:
  - out_code = mem[rd_ptr], driven combinationally from the storage array.
  - out_code is don't-care while empty; the RTL drives 0.
- Latency: an event sampled at posedge N with the FIFO empty gives out_valid = 1 and the matching out_code right after edge N.
  - A pop at edge N exposes the next entry right after edge N.
- Pointers wrap modulo DEPTH; count is held separately, so full and empty are never ambiguous.
- count update: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- Holding out_valid: once asserted, out_valid stays high with out_code stable until popped (standard valid/ready rule).
- in_valid = 0: no event is generated and in_code is ignored for capture, but prev_code still tracks it.

Decomposition:
- Package pe_pkg:
  - localparam PE_CODE_W = 2.
  - typedef logic [PE_CODE_W-1:0] pe_code_t.
  - shared by the priority encoder and this block.
- Sub-module pe_fifo_core: generic synchronous FIFO (storage, pointers, count, full/empty, push/pop handshake).
- pe_event_fifo contains the event-detect registers, drop/overflow logic and drop counter around pe_fifo_core.

Test Plan (DEPTH=4, CNT_W=8 unless stated):
- Reset: fill 2 entries, pull rst=0 between edges → count=0, empty=1, out_valid=0, overflow=0, drop_cnt=0 at once (no clock edge); remains so for 2 cycles after release.
- Dedup: in_valid=1, in_code=01 held 10 cycles, out_ready=0 → count=1, out_code=01; no further pushes.
- Ordering/full: codes 00,01,10,11 one cycle each with in_valid=1, out_ready=0 → count=4, full=1; then out_ready=1 pops 00,01,10,11 over 4 consecutive cycles, ending with empty=1.
- Overflow vs. concurrent pop: full holding 00..11, apply code 00 with out_ready=0 → dropped, overflow=1, drop_cnt=1, count=4. Repeat with new code 10 and out_ready=1 in the same cycle → accepted, count stays 4, tail = 10.
- Re-arm on valid: in_code=10, in_valid 1→0→1 → two separate 10 entries captured (count=2).
- Saturation/clear: CNT_W=2, force 5 drops → drop_cnt=3, overflow=1. clr_ovf=1 alone → both 0. clr_ovf together with a drop → overflow=1, drop_cnt=1.
